// File: rtl/clock_divider_pkg.sv
// Shared constants for the multi-channel clock divider: default divisor,
// channel limit and the channel-index width helper.
package clock_divider_pkg;

   localparam int unsigned MAX_CH      = 16;
   localparam int unsigned DIV_DEFAULT = 25_000_000;

   // A single-channel build still gets a 1-bit select port.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/pending divisor and registered
// clock_out / tick_out outputs.
module clock_divider_channel
   import clock_divider_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             en,
   input  logic             sync_restart,
   input  logic             load,
   input  logic [WIDTH-1:0] load_div,
   output logic             clock_out,
   output logic             tick_out,
   output logic             cfg_pending
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_act;
   logic [WIDTH-1:0] div_pend;
   logic             pend_v;
   logic             clk_q;
   logic             tick_q;
   logic             running;
   logic             tc;

   assign running = en && (div_act != '0);
   assign tc      = running && (cnt == div_act - WIDTH'(1));

   always_ff @(posedge clock_in) begin
      if (reset) begin
         cnt      <= '0;
         div_act  <= DIV_RST;
         div_pend <= '0;
         pend_v   <= 1'b0;
         clk_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         // A new divisor only lands on a period boundary, so cnt never exceeds it.
         if ((sync_restart || !running || tc) && pend_v) begin
            div_act <= div_pend;
            pend_v  <= 1'b0;
         end
         if (sync_restart || !running) begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else if (tc) begin
            cnt    <= '0;
            clk_q  <= ~clk_q;
            tick_q <= 1'b1;
         end else begin
            cnt    <= cnt + WIDTH'(1);
            tick_q <= 1'b0;
         end
         // Placed last: a coincident load stays pending past this edge's apply.
         if (load) begin
            div_pend <= load_div;
            pend_v   <= 1'b1;
         end
      end
   end

   assign clock_out   = clk_q;
   assign tick_out    = tick_q;
   assign cfg_pending = pend_v;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH runtime-programmable clock dividers on one clock_in, with a shared
// phase-aligning restart and a single divisor write port.
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = DIV_DEFAULT,
   localparam int unsigned CH_W       = ch_idx_w(NUM_CH)
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync_restart,
   input  logic              cfg_load,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [WIDTH-1:0]  cfg_div,
   output logic [NUM_CH-1:0] clock_out,
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] cfg_pending
);

   logic [NUM_CH-1:0] load_v;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Selects at or beyond NUM_CH match no channel and are dropped.
      assign load_v[i] = cfg_load && (cfg_ch == CH_W'(i));

      clock_divider_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clock_in     (clock_in),
         .reset        (reset),
         .en           (en[i]),
         .sync_restart (sync_restart),
         .load         (load_v[i]),
         .load_div     (cfg_div),
         .clock_out    (clock_out[i]),
         .tick_out     (tick_out[i]),
         .cfg_pending  (cfg_pending[i])
      );
   end

endmodule
